// File: rtl/simon_pkg.sv
// Shared Simon 128/256 constants, FSM state type and round/key-schedule helpers.
// The encryption core reuses the same functions.
package simon_pkg;

  localparam int unsigned N         = 64;
  localparam int unsigned ROUNDS    = 72;
  localparam int unsigned KEY_WORDS = 4;
  localparam logic [63:0] Z         = 64'h3DC94C3A046D678B;

  typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int unsigned s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int unsigned s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] a);
    return rol(a, 2) ^ (rol(a, 1) & rol(a, 8));
  endfunction

  // Index only reaches 0..67 in valid operation, so one mod 62 is exact.
  function automatic logic z_bit(input logic [6:0] idx);
    logic [5:0] m;
    m = 6'(idx % 7'd62);
    return Z[m];
  endfunction

  function automatic logic [N-1:0] key_mix(input logic [N-1:0] k3, input logic [N-1:0] k1);
    logic [N-1:0] t;
    t = ror(k3, 3) ^ k1;
    return t ^ ror(t, 1);
  endfunction

  // k[j+4] from k[j+3], k[j+1], k[j].
  function automatic logic [N-1:0] key_fwd(input logic [N-1:0] k3, input logic [N-1:0] k1,
                                           input logic [N-1:0] k0, input logic [6:0] idx);
    return ~k0 ^ 64'h3 ^ key_mix(k3, k1) ^ {63'b0, z_bit(idx)};
  endfunction

  // k[i] from k[i+4], k[i+3], k[i+1].
  function automatic logic [N-1:0] key_inv(input logic [N-1:0] k4, input logic [N-1:0] k3,
                                           input logic [N-1:0] k1, input logic [6:0] idx);
    return ~(k4 ^ 64'h3 ^ key_mix(k3, k1) ^ {63'b0, z_bit(idx)});
  endfunction

endpackage

// File: rtl/simon_decrypt_if.sv
// Start/done control and data bus of the Simon decryption core.
interface simon_decrypt_if;
  logic         start;
  logic [255:0] keys;
  logic [127:0] in;
  logic [127:0] out;
  logic         done;
  logic         busy;

  modport master (output start, keys, in, input out, done, busy);
  modport slave  (input start, keys, in, output out, done, busy);
endinterface

// File: rtl/simon_key_window.sv
// Four-word sliding key window: steps the schedule forward during expansion and
// regenerates earlier round keys backwards during decryption.
module simon_key_window
  import simon_pkg::*;
(
  input  logic           clk,
  input  logic           res,
  input  logic           load_i,
  input  logic           fwd_i,
  input  logic           back_i,
  input  logic [6:0]     idx_i,
  input  logic [255:0]   keys_i,
  output logic [N-1:0]   top_o
);

  logic [3:0][N-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (load_i) begin
      win_d = keys_i;
    end else if (fwd_i) begin
      win_d = {key_fwd(win_q[3], win_q[1], win_q[0], idx_i), win_q[3:1]};
    end else if (back_i) begin
      win_d = {win_q[2:0], key_inv(win_q[3], win_q[2], win_q[0], idx_i)};
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign top_o = win_q[3];

endmodule

// File: rtl/simon_decrypt.sv
// Simon 128/256 decryption core: 68-cycle forward key expansion, then 72 inverse
// rounds consuming round keys from the window in reverse order.
module simon_decrypt
  import simon_pkg::*;
(
  input logic            clk,
  input logic            res,
  simon_decrypt_if.slave bus
);

  localparam logic [6:0] LastExpand = 7'(ROUNDS - KEY_WORDS - 1);
  localparam logic [6:0] LastRound  = 7'(ROUNDS - 1);

  state_e         state_q, state_d;
  logic [6:0]     ctr_q, ctr_d;
  logic [N-1:0]   u_q, u_d, l_q, l_d;
  logic           load, fwd, back;
  logic [6:0]     key_idx;
  logic [N-1:0]   k_top;

  simon_key_window u_key_window (
    .clk    (clk),
    .res    (res),
    .load_i (load),
    .fwd_i  (fwd),
    .back_i (back),
    .idx_i  (key_idx),
    .keys_i (bus.keys),
    .top_o  (k_top)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    u_d     = u_q;
    l_d     = l_q;
    load    = 1'b0;
    fwd     = 1'b0;
    back    = 1'b0;
    key_idx = ctr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          load    = 1'b1;
          u_d     = bus.in[127:64];
          l_d     = bus.in[63:0];
          ctr_d   = '0;
          state_d = StExpand;
        end
      end
      StExpand: begin
        fwd = 1'b1;
        if (ctr_q == LastExpand) begin
          ctr_d   = LastRound;
          state_d = StDecrypt;
        end else begin
          ctr_d = ctr_q + 7'd1;
        end
      end
      StDecrypt: begin
        back    = 1'b1;
        // Wraps for r<4; the regenerated key is never used then.
        key_idx = ctr_q - 7'd4;
        u_d     = l_q ^ k_top ^ simon_f(u_q);
        l_d     = u_q;
        if (ctr_q == '0) begin
          state_d = StDone;
        end else begin
          ctr_d = ctr_q - 7'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      u_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      u_q     <= u_d;
      l_q     <= l_d;
    end
  end

  assign bus.out  = {u_q, l_q};
  assign bus.done = (state_q == StDone);
  assign bus.busy = (state_q == StExpand) || (state_q == StDecrypt);

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed and loopback bench for simon_decrypt; the reference is a forward
// Simon 128/256 encryption model.
module tb_simon_decrypt;

  logic clk;
  logic res;
  int   n_checks;
  int   n_fail;

  simon_decrypt_if bus ();

  simon_decrypt dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] PaperKey = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                                       64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] PaperCt  = {64'h3bf72a87efe7b868, 64'h8d2b5579afc8a3a0};
  localparam logic [127:0] PaperPt  = {64'h6d69732061207369, 64'h74206e69206d6f6f};

  function automatic logic [63:0] bf(input logic [63:0] x);
    return ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [255:0] k, input logic [127:0] p);
    logic [63:0] ks [0:71];
    logic [63:0] zc;
    logic [63:0] t, x, y, tmp;
    zc = 64'h3DC94C3A046D678B;
    for (int i = 0; i < 4; i++) ks[i] = k[64*i +: 64];
    for (int i = 0; i < 68; i++) begin
      t = {ks[i+3][2:0], ks[i+3][63:3]} ^ ks[i+1];
      t = t ^ {t[0], t[63:1]};
      ks[i+4] = ks[i] ^ 64'hFFFF_FFFF_FFFF_FFFC ^ t ^ {63'b0, zc[i % 62]};
    end
    y = p[127:64];
    x = p[63:0];
    for (int r = 0; r < 72; r++) begin
      tmp = x;
      x   = y ^ bf(x) ^ ks[r];
      y   = tmp;
    end
    return {y, x};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Caller is at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [255:0] k, input logic [127:0] c);
    bus.start = 1'b1;
    bus.keys  = k;
    bus.in    = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.keys  = rand256();
    bus.in    = rand128();
  endtask

  // lat = edges after the accept edge until done is seen; bounded.
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out !== 128'h0) begin
      n_fail++; $display("FAIL reset_out got=%h want=0", bus.out);
    end
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    res = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_paper_vector();
    int lat;
    start_op(PaperKey, PaperCt);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL paper_busy got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat !== 140) begin
      n_fail++; $display("FAIL paper_latency got=%0d want=140", lat);
    end
    n_checks++;
    if (bus.out !== PaperPt) begin
      n_fail++; $display("FAIL paper_out got=%h want=%h", bus.out, PaperPt);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL paper_busy_low got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_loopback();
    logic [255:0] k;
    logic [127:0] p;
    int lat;
    for (int n = 0; n < 200; n++) begin
      k = rand256();
      p = rand128();
      start_op(k, model_encrypt(k, p));
      wait_done(0, lat);
      n_checks++;
      if (lat !== 140) begin
        n_fail++; $display("FAIL loop_latency[%0d] got=%0d want=140", n, lat);
      end
      n_checks++;
      if (bus.out !== p) begin
        n_fail++; $display("FAIL loop_out[%0d] got=%h want=%h", n, bus.out, p);
      end
    end
  endtask

  task automatic reset_mid(input int at_cycle, input string name);
    int lat;
    start_op(rand256(), rand128());
    repeat (at_cycle - 1) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out !== 128'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got out=%h done=%b busy=%b want 0 0 0", name, bus.out, bus.done, bus.busy);
    end
    res = 1'b0;
    @(negedge clk);
    start_op(PaperKey, PaperCt);
    wait_done(0, lat);
    n_checks++;
    if (bus.out !== PaperPt || lat !== 140) begin
      n_fail++; $display("FAIL %s_after got=%h lat=%0d want=%h lat=140", name, bus.out, lat, PaperPt);
    end
  endtask

  task automatic test_reset_mid();
    reset_mid(50, "reset_expand");
    reset_mid(100, "reset_decrypt");
  endtask

  task automatic test_start_while_busy();
    logic [255:0] k;
    logic [127:0] p;
    int lat;
    int elapsed;
    k = rand256();
    p = rand128();
    start_op(k, model_encrypt(k, p));
    elapsed = 0;
    for (int n = 0; n < 8; n++) begin
      bus.start = 1'b1;
      bus.keys  = rand256();
      bus.in    = rand128();
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      elapsed += 10;
    end
    wait_done(elapsed, lat);
    n_checks++;
    if (bus.out !== p || lat !== 140) begin
      n_fail++; $display("FAIL busy_start got=%h lat=%0d want=%h lat=140", bus.out, lat, p);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    logic [127:0] p;
    int lat;
    start_op(PaperKey, PaperCt);
    wait_done(0, lat);
    k = rand256();
    p = rand128();
    start_op(k, model_encrypt(k, p));
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got done=%b busy=%b want 0 1", bus.done, bus.busy);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat !== 140) begin
      n_fail++; $display("FAIL b2b_latency got=%0d want=140", lat);
    end
    n_checks++;
    if (bus.out !== p) begin
      n_fail++; $display("FAIL b2b_out got=%h want=%h", bus.out, p);
    end
  endtask

  task automatic test_res_and_start();
    // Core sits in DONE here, so a won start would visibly raise busy.
    res       = 1'b1;
    bus.start = 1'b1;
    bus.keys  = PaperKey;
    bus.in    = PaperCt;
    @(negedge clk);
    res       = 1'b0;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL res_start got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out !== 128'h0) begin
      n_fail++; $display("FAIL res_start_idle got busy=%b out=%h want 0 0", bus.busy, bus.out);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    res       = 1'b1;
    bus.start = 1'b0;
    bus.keys  = '0;
    bus.in    = '0;
    @(negedge clk);
    test_reset();
    test_paper_vector();
    test_loopback();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_res_and_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
